// File: rtl/pipeline_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_fetch_pkg
//   Shared constants and types for the instruction fetch stage.
//   NOP_INSTRUCTION : word presented to decode when nothing is available
//                     (addi x0, x0, 0)
//   INITIAL_PC      : default first fetch address after reset
//   fetch_entry_t   : one instruction queue entry {inst, pc}
// -----------------------------------------------------------------------------
package pipeline_fetch_pkg;

   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
   localparam logic [31:0] INITIAL_PC      = 32'h0040_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/pipeline_fetch_queue.sv
// -----------------------------------------------------------------------------
// pipeline_fetch_queue
//   Generic synchronous FIFO: the fetch stage uses it for its instruction
//   queue, and the LSU is expected to reuse it for its own buffering.
//   DEPTH must be a power of two (>= 2) so the pointers wrap on their own.
//   Ports:
//     clk_i, rst_i : clock, asynchronous active-high reset
//     push_i       : write data_i at the tail (ignored when full unless popping)
//     data_i       : entry to write
//     pop_i        : drop the head entry (ignored when empty)
//     flush_i      : empty the FIFO; takes priority over push/pop
//     full_o       : DEPTH entries held
//     empty_o      : no entries held
//     count_o      : number of entries held
//     head_o       : oldest entry (undefined while empty)
// -----------------------------------------------------------------------------
module pipeline_fetch_queue
   import pipeline_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [WIDTH-1:0]             head_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/pipeline_fetch.sv
// -----------------------------------------------------------------------------
// pipeline_fetch
//   Instruction fetch stage ahead of decode. Holds the fetch PC, issues up to
//   MAX_OUTSTANDING in-order requests to instruction memory, queues responses
//   with their PC and presents the head to decode. A redirect flushes
//   everything and restarts fetch; responses to requests already in flight
//   are counted off in drop_q and discarded.
//   Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, a response
//   arriving while the queue is empty is shown to decode in the same cycle
//   (and not enqueued if decode consumes it at once). When undefined, decode
//   only ever sees the queue head and rdata has no combinational path to inst.
//   Ports:
//     clock, reset                 : clock, asynchronous active-high reset
//     inst_mem_req/addr/ready      : request handshake (accepted on req && ready)
//     inst_mem_rvalid/rdata        : in-order responses, one per accepted request
//     redirect_valid/redirect_pc   : restart fetch at redirect_pc (top priority)
//     consume                      : decode takes the head instruction
//     inst_available/inst/inst_pc  : instruction presented to decode
//   Handshakes: a request transfers on the cycle inst_mem_req && inst_mem_ready;
//   a response transfers on every inst_mem_rvalid cycle; decode takes an
//   instruction on the cycle consume && inst_available (and no redirect).
//   State (no FSM): fetch_pc, resp_pc, queue, outstanding, drop.
// -----------------------------------------------------------------------------
module pipeline_fetch
   import pipeline_fetch_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH     = 2,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = INITIAL_PC
) (
   input  logic        clock,
   input  logic        reset,
   output logic        inst_mem_req,
   output logic [31:0] inst_mem_addr,
   input  logic        inst_mem_ready,
   input  logic        inst_mem_rvalid,
   input  logic [31:0] inst_mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        consume,
   output logic        inst_available,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);
   localparam int unsigned CW = $clog2(QUEUE_DEPTH+1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [OW-1:0] outstanding_q, outstanding_d;
   logic [OW-1:0] drop_q, drop_d;

   logic          req, fire, resp_keep, bypass_hit, q_push, q_pop;
   logic [CW-1:0] q_count;
   logic          q_full, q_empty;
   fetch_entry_t  q_head, push_entry;

   always_comb begin
      // Credit rule: every in-flight request already owns a queue slot.
      req = !reset && !redirect_valid
            && (32'(outstanding_q) < MAX_OUTSTANDING)
            && ((32'(q_count) + 32'(outstanding_q)) < QUEUE_DEPTH);
      fire      = req && inst_mem_ready;
      resp_keep = inst_mem_rvalid && !redirect_valid && (drop_q == '0);
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass_hit = resp_keep && q_empty;
`else
      bypass_hit = 1'b0;
`endif
      // A bypassed response that decode takes immediately never enters the queue.
      q_push     = resp_keep && !(bypass_hit && consume);
      q_pop      = consume && !q_empty && !redirect_valid;
      push_entry = '{inst: inst_mem_rdata, pc: resp_pc_q};

      outstanding_d = outstanding_q;
      if (fire)            outstanding_d = outstanding_d + OW'(1);
      if (inst_mem_rvalid) outstanding_d = outstanding_d - OW'(1);

      drop_d     = drop_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      if (fire)      fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_keep) resp_pc_d  = resp_pc_q + 32'd4;
      if (inst_mem_rvalid && (drop_q != '0)) drop_d = drop_q - OW'(1);
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         // Everything still in flight after this cycle belongs to the old path.
         drop_d     = outstanding_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   pipeline_fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (FETCH_ENTRY_W)
   ) u_queue (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (q_push),
      .data_i  (push_entry),
      .pop_i   (q_pop),
      .flush_i (redirect_valid),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count),
      .head_o  (q_head)
   );

   always_comb begin
      inst_mem_req   = req;
      inst_mem_addr  = fetch_pc_q;
      inst_available = !q_empty || bypass_hit;
      if (!q_empty) begin
         inst    = q_head.inst;
         inst_pc = q_head.pc;
      end else if (bypass_hit) begin
         inst    = inst_mem_rdata;
         inst_pc = resp_pc_q;
      end else begin
         // Idle: show a NOP tagged with the PC of the next expected instruction.
         inst    = NOP_INSTRUCTION;
         inst_pc = resp_pc_q;
      end
   end

`ifndef SYNTHESIS
   a_rvalid_needs_outstanding: assert property (@(posedge clock) disable iff (reset)
      inst_mem_rvalid |-> (outstanding_q != '0));
   a_addr_aligned: assert property (@(posedge clock) disable iff (reset)
      inst_mem_req |-> (inst_mem_addr[1:0] == 2'b00));
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      (q_push && q_full) |-> q_pop);
   a_drop_bounded: assert property (@(posedge clock) disable iff (reset)
      drop_q <= outstanding_q);
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
module tb_pipeline_fetch;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          MAXO   = 2;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam logic        BYP    = 1'b1;
`else
   localparam logic        BYP    = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic        clock = 1'b0;
   logic        reset;
   always #5 clock = ~clock;

   logic        inst_mem_req;
   logic [31:0] inst_mem_addr;
   logic        inst_mem_ready;
   logic        inst_mem_rvalid;
   logic [31:0] inst_mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        consume;
   logic        inst_available;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   pipeline_fetch #(
      .QUEUE_DEPTH     (2),
      .MAX_OUTSTANDING (MAXO),
      .RESET_PC        (RST_PC)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .inst_mem_req    (inst_mem_req),
      .inst_mem_addr   (inst_mem_addr),
      .inst_mem_ready  (inst_mem_ready),
      .inst_mem_rvalid (inst_mem_rvalid),
      .inst_mem_rdata  (inst_mem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .consume         (consume),
      .inst_available  (inst_available),
      .inst            (inst),
      .inst_pc         (inst_pc)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] pend_q[$];     // addresses accepted by memory, awaiting response
   logic        s_req, s_av;
   logic [31:0] s_addr, s_inst, s_pc;
   int          s_pend;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // One cycle: drive after the falling edge, sample 1ns later, update the
   // memory model with what transferred in this cycle.
   task automatic cyc(input logic rdy, input logic rv, input logic cons,
                      input logic redir, input logic [31:0] rpc,
                      input logic ovr, input logic [31:0] ovr_data);
      @(negedge clock);
      inst_mem_ready  = rdy;
      inst_mem_rvalid = rv;
      inst_mem_rdata  = 32'h0;
      if (rv && pend_q.size() != 0) inst_mem_rdata = ovr ? ovr_data : mem_word(pend_q[0]);
      consume         = cons;
      redirect_valid  = redir;
      redirect_pc     = rpc;
      #1;
      s_req  = inst_mem_req;
      s_addr = inst_mem_addr;
      s_av   = inst_available;
      s_inst = inst;
      s_pc   = inst_pc;
      s_pend = pend_q.size();
      if (rv && pend_q.size() != 0) void'(pend_q.pop_front());
      if (s_req && rdy) pend_q.push_back(s_addr);
   endtask

   task automatic idle_inputs();
      inst_mem_ready  = 1'b0;
      inst_mem_rvalid = 1'b0;
      inst_mem_rdata  = 32'h0;
      consume         = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
   endtask

   task automatic do_reset(input string tag);
      idle_inputs();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      #1;
      chk({tag, "_rst_req"},  {31'b0, inst_mem_req},   32'd0);
      chk({tag, "_rst_av"},   {31'b0, inst_available}, 32'd0);
      chk({tag, "_rst_inst"}, inst,    NOP);
      chk({tag, "_rst_pc"},   inst_pc, RST_PC);
      reset = 1'b0;
      pend_q.delete();
   endtask

   // ---------------- table-driven vectors ----------------
   typedef struct {
      logic        rdy, rv, cons;
      logic        ereq;
      logic [31:0] eaddr;
      logic        eav, eav_byp;
      logic [31:0] epc;
   } vec_t;
   vec_t tbl[11];

   initial begin
      logic        rdy, rv, cons, redir, eav;
      logic [31:0] rpc, exp_fetch, exp_pc;
      int          consumed;

      // back-pressure from decode, then release, then a 0-wait response
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0004, 1'b0, 1'b1, 32'h0040_0000};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0000};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0000};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0000};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0008, 1'b1, 1'b1, 32'h0040_0004};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0004};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0004};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_000C, 1'b1, 1'b1, 32'h0040_0008};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0010, 1'b0, 1'b1, 32'h0040_000C};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_000C};

      do_reset("tbl");
      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].rdy, tbl[i].rv, tbl[i].cons, 1'b0, 32'h0, 1'b0, 32'h0);
         chk($sformatf("tbl%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].ereq});
         if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].eaddr);
         eav = BYP ? tbl[i].eav_byp : tbl[i].eav;
         chk($sformatf("tbl%0d_av", i), {31'b0, s_av}, {31'b0, eav});
         if (eav) begin
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].epc);
            chk($sformatf("tbl%0d_inst", i), s_inst, mem_word(tbl[i].epc));
         end else begin
            chk($sformatf("tbl%0d_nop", i), s_inst, NOP);
         end
      end

      // ---- redirect with two requests in flight ----
      do_reset("redir");
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("redir_addr0", s_addr, 32'h0040_0000);
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("redir_addr1", s_addr, 32'h0040_0004);
      cyc(1, 0, 0, 1, 32'h0040_0100, 0, 32'h0);
      chk("redir_noreq", {31'b0, s_req}, 32'd0);
      cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
      chk("redir_full_noreq", {31'b0, s_req}, 32'd0);
      chk("redir_drop0_av", {31'b0, s_av}, 32'd0);
      cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
      chk("redir_req_new", {31'b0, s_req}, 32'd1);
      chk("redir_addr_new", s_addr, 32'h0040_0100);
      chk("redir_drop1_av", {31'b0, s_av}, 32'd0);
      cyc(0, 1, 0, 0, 32'h0, 0, 32'h0);
      chk("redir_resp_av", {31'b0, s_av}, {31'b0, BYP});
      cyc(0, 0, 1, 0, 32'h0, 0, 32'h0);
      chk("redir_first_av", {31'b0, s_av}, 32'd1);
      chk("redir_first_pc", s_pc, 32'h0040_0100);
      chk("redir_first_inst", s_inst, mem_word(32'h0040_0100));

      // ---- redirect, rvalid and consume in the same cycle ----
      do_reset("same");
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      cyc(0, 1, 0, 0, 32'h0, 0, 32'h0);
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("same_addr", s_addr, 32'h0040_0004);
      chk("same_head_pc", s_pc, 32'h0040_0000);
      cyc(1, 1, 1, 1, 32'h0040_0200, 0, 32'h0);
      chk("same_noreq", {31'b0, s_req}, 32'd0);
      cyc(0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("same_av_after", {31'b0, s_av}, 32'd0);
      chk("same_req_after", {31'b0, s_req}, 32'd1);
      chk("same_addr_after", s_addr, 32'h0040_0200);
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      cyc(0, 1, 0, 0, 32'h0, 0, 32'h0);
      cyc(0, 0, 1, 0, 32'h0, 0, 32'h0);
      chk("same_first_pc", s_pc, 32'h0040_0200);
      chk("same_first_inst", s_inst, mem_word(32'h0040_0200));

      // ---- response-to-decode latency on an empty queue ----
      do_reset("lat");
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      cyc(0, 1, 0, 0, 32'h0, 1, 32'h00A0_0093);
      chk("lat_av_same", {31'b0, s_av}, {31'b0, BYP});
      chk("lat_inst_same", s_inst, BYP ? 32'h00A0_0093 : NOP);
      chk("lat_pc_same", s_pc, 32'h0040_0000);
      cyc(0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("lat_av_next", {31'b0, s_av}, 32'd1);
      chk("lat_inst_next", s_inst, 32'h00A0_0093);
      chk("lat_pc_next", s_pc, 32'h0040_0000);

      // ---- reset mid-stream with two requests in flight ----
      do_reset("mid");
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      cyc(0, 1, 0, 0, 32'h0, 0, 32'h0);
      chk("mid_pre_addr", s_addr, 32'h0040_0008);
      idle_inputs();
      reset = 1'b1;
      #1;
      chk("mid_rst_req", {31'b0, inst_mem_req}, 32'd0);
      chk("mid_rst_addr", inst_mem_addr, RST_PC);
      chk("mid_rst_av", {31'b0, inst_available}, 32'd0);
      chk("mid_rst_inst", inst, NOP);
      chk("mid_rst_pc", inst_pc, RST_PC);
      pend_q.delete();
      @(negedge clock);
      #1;
      reset = 1'b0;
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("mid_req_after", {31'b0, s_req}, 32'd1);
      chk("mid_addr_after", s_addr, RST_PC);
      cyc(0, 1, 0, 0, 32'h0, 0, 32'h0);
      cyc(0, 0, 1, 0, 32'h0, 0, 32'h0);
      chk("mid_first_pc", s_pc, RST_PC);
      chk("mid_first_inst", s_inst, mem_word(RST_PC));

      // ---- randomized traffic against the instruction-stream model ----
      // Decode must see mem_word(pc) for pc = start, start+4, ... restarting
      // at each redirect target; requests must walk the same sequence.
      do_reset("rnd");
      exp_fetch = RST_PC;
      exp_pc    = RST_PC;
      consumed  = 0;
      for (int i = 0; i < 4000; i++) begin
         rdy   = ($urandom_range(0, 3) != 0);
         rv    = (pend_q.size() != 0) && ($urandom_range(0, 2) != 0);
         cons  = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 24) == 0);
         rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                 : (32'h0010_0000 | (32'($urandom_range(0, 4095)) << 2));
         cyc(rdy, rv, cons, redir, rpc, 1'b0, 32'h0);
         if (redir) chk("rnd_req_on_redirect", {31'b0, s_req}, 32'd0);
         if (s_req) chk("rnd_credit", {31'b0, (s_pend < MAXO)}, 32'd1);
         if (s_req && rdy) begin
            chk("rnd_addr", s_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (s_av && cons && !redir) begin
            chk("rnd_pc", s_pc, exp_pc);
            chk("rnd_inst", s_inst, mem_word(exp_pc));
            exp_pc   = exp_pc + 32'd4;
            consumed = consumed + 1;
         end
         if (redir) begin
            exp_fetch = rpc;
            exp_pc    = rpc;
         end
      end
      chk("rnd_progress", {31'b0, (consumed > 500)}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
